// File: rtl/im_load_arbiter_if.sv
// rtl/im_load_arbiter_if.sv - fetch, loader and IM port signals shared by the arbiter and its neighbours
interface im_load_arbiter_if #(
  parameter int AW    = 11,
  parameter int DW    = 16,
  parameter int LEN_W = 12
);
  logic [AW-1:0]    fetch_addr;
  logic             fetch_rd_en;
  logic             cpu_stall;
  logic             ld_start;
  logic [AW-1:0]    ld_base;
  logic [LEN_W-1:0] ld_len;
  logic             ld_abort;
  logic [7:0]       ld_byte;
  logic             ld_vld;
  logic             ld_rdy;
  logic [AW-1:0]    im_addr;
  logic             im_rd_en;
  logic             im_wr_en;
  logic [DW-1:0]    im_wdata;
  logic             load_done;
  logic             load_err;

  modport slave (
    input  fetch_addr, fetch_rd_en, ld_start, ld_base, ld_len, ld_abort, ld_byte, ld_vld,
    output cpu_stall, ld_rdy, im_addr, im_rd_en, im_wr_en, im_wdata, load_done, load_err
  );

  modport master (
    output fetch_addr, fetch_rd_en, ld_start, ld_base, ld_len, ld_abort, ld_byte, ld_vld,
    input  cpu_stall, ld_rdy, im_addr, im_rd_en, im_wr_en, im_wdata, load_done, load_err
  );
endinterface

// File: rtl/im_load_arbiter.sv
// rtl/im_load_arbiter.sv - shares the IM port between CPU fetch and the UART program loader
// DW must be 16: each word is packed big-endian from two loader bytes.
module im_load_arbiter #(
  parameter int AW    = 11,
  parameter int DW    = 16,
  parameter int LEN_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  im_load_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    ptr;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [7:0]       hi_byte;
  logic [DW-1:0]    wdata_q;
  logic             err_q;
  logic             start_ok;
  logic             abort_act;

  assign cnt_inc   = cnt + LEN_W'(1);
  assign start_ok  = bus.ld_start && (bus.ld_len != '0);
  assign abort_act = bus.ld_abort &&
                     ((state == S_DRAIN) || (state == S_HI) || (state == S_LO) || (state == S_WR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = abort_act ? S_IDLE : S_HI;
      S_HI: begin
        if (abort_act)       state_nxt = S_IDLE;
        else if (bus.ld_vld) state_nxt = S_LO;
      end
      S_LO: begin
        if (abort_act)       state_nxt = S_IDLE;
        else if (bus.ld_vld) state_nxt = S_WR;
      end
      S_WR: begin
        if (abort_act)          state_nxt = S_IDLE;
        else if (cnt_inc == len) state_nxt = S_DONE;
        else                    state_nxt = S_HI;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A write already on the port in WR completes even if abort arrives that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      len     <= '0;
      cnt     <= '0;
      hi_byte <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (abort_act) err_q <= 1'b1;
      case (state)
        S_IDLE: if (start_ok) begin
          ptr   <= bus.ld_base;
          len   <= bus.ld_len;
          cnt   <= '0;
          err_q <= 1'b0;
        end
        S_HI: if (bus.ld_vld && !abort_act) hi_byte <= bus.ld_byte;
        S_LO: if (bus.ld_vld && !abort_act) wdata_q <= {hi_byte, bus.ld_byte};
        S_WR: begin
          ptr <= ptr + AW'(1);
          cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cpu_stall = 1'b1;
    bus.ld_rdy    = 1'b0;
    bus.im_addr   = ptr;
    bus.im_rd_en  = 1'b0;
    bus.im_wr_en  = 1'b0;
    bus.load_done = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cpu_stall = 1'b0;
        bus.im_addr   = bus.fetch_addr;
        bus.im_rd_en  = bus.fetch_rd_en;
      end
      S_DRAIN: bus.im_addr   = bus.fetch_addr;
      S_HI:    bus.ld_rdy    = 1'b1;
      S_LO:    bus.ld_rdy    = 1'b1;
      S_WR:    bus.im_wr_en  = 1'b1;
      S_DONE:  bus.load_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.im_wdata = wdata_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_im_load_arbiter.sv
// tb/tb_im_load_arbiter.sv - scoreboard bench for im_load_arbiter
module tb_im_load_arbiter;
  localparam int AW = 11, DW = 16, LEN_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  im_load_arbiter_if #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) bus ();

  im_load_arbiter #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Writes are checked against the scoreboard as they appear on the IM port.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bus.im_wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.im_addr, bus.im_wdata} !== e) begin
          n_err++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   bus.im_addr, bus.im_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (bus.load_done) done_cnt++;
    if (bus.cpu_stall) begin
      n_cmp++;
      if (bus.im_rd_en !== 1'b0) begin
        n_err++;
        $display("FAIL rd_during_stall: got im_rd_en=%b, required 0", bus.im_rd_en);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW-1:0] base, input logic [LEN_W-1:0] n);
    bus.ld_base  = base;
    bus.ld_len   = n;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.ld_byte = b;
    bus.ld_vld  = 1'b1;
    @(negedge clk);
    while (!bus.ld_rdy && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_timeout: got ld_rdy=0 for 50 cycles, required ld_rdy=1");
    end
    tick();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.load_done && t < 40) begin
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (!bus.load_done) begin
      n_err++;
      $display("FAIL done_timeout: got load_done=0, required pulse");
    end
    n_cmp++;
    if (bus.cpu_stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_in_done: got %b, required 1", bus.cpu_stall);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_stall !== 1'b0 || bus.load_done !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after_done: got stall=%b done=%b, required 0 0", bus.cpu_stall, bus.load_done);
    end
  endtask

  task automatic test_reset();
    bus.fetch_addr = 11'h3AB; bus.fetch_rd_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.cpu_stall, bus.ld_rdy, bus.im_wr_en, bus.load_done, bus.load_err} !== 5'b0 ||
        bus.im_wdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got stall=%b rdy=%b wr=%b done=%b err=%b wdata=%h, required all 0",
               bus.cpu_stall, bus.ld_rdy, bus.im_wr_en, bus.load_done, bus.load_err, bus.im_wdata);
    end
    n_cmp++;
    if (bus.im_addr !== 11'h3AB || bus.im_rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_passthrough: got addr=%h rd=%b, required 3ab 1", bus.im_addr, bus.im_rd_en);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    bus.fetch_addr = 11'h123; bus.fetch_rd_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.im_addr !== 11'h123 || bus.im_rd_en !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.im_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough: got addr=%h rd=%b stall=%b wr=%b, required 123 1 0 0",
               bus.im_addr, bus.im_rd_en, bus.cpu_stall, bus.im_wr_en);
    end
    bus.fetch_rd_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.im_rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL passthrough_rd_off: got %b, required 0", bus.im_rd_en);
    end
    bus.fetch_rd_en = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int d0;
    d0 = done_cnt;
    exp_q.push_back({11'h010, 16'hA1B2});
    exp_q.push_back({11'h011, 16'hC3D4});
    start_load(11'h010, 12'd2);
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_stall !== 1'b1 || bus.im_rd_en !== 1'b0 || bus.ld_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got stall=%b rd=%b rdy=%b, required 1 0 0", bus.cpu_stall, bus.im_rd_en, bus.ld_rdy);
    end
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    bus.ld_vld = 1'b0;
    wait_done();
    repeat (3) tick();
    n_cmp++;
    if (done_cnt !== d0 + 1 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL load_done_count: got pulses=%0d pending=%0d, required 1 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back({11'h7FF, 16'h1122});
    exp_q.push_back({11'h000, 16'h3344});
    start_load(11'h7FF, 12'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    bus.ld_vld = 1'b0;
    wait_done();
    tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL wrap_pending: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    bus.fetch_addr = 11'h2C4;
    exp_q.push_back({11'h040, 16'h5566});
    start_load(11'h040, 12'd2);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    bus.ld_vld = 1'b0;
    bus.ld_abort = 1'b1;
    tick();
    bus.ld_abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.load_err !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.im_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got err=%b stall=%b wr=%b, required 1 0 0", bus.load_err, bus.cpu_stall, bus.im_wr_en);
    end
    n_cmp++;
    if (bus.im_addr !== 11'h2C4 || bus.im_rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL abort_passthrough: got addr=%h rd=%b, required 2c4 1", bus.im_addr, bus.im_rd_en);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt !== d0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL abort_writes: got pulses=%0d pending=%0d, required 0 0", done_cnt - d0, exp_q.size());
    end
    exp_q.push_back({11'h050, 16'h1234});
    start_load(11'h050, 12'd1);
    @(negedge clk);
    n_cmp++;
    if (bus.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got load_err=%b, required 0", bus.load_err);
    end
    send_byte(8'h12); send_byte(8'h34);
    bus.ld_vld = 1'b0;
    wait_done();
    tick();
  endtask

  task automatic test_gaps();
    int d0;
    exp_q.push_back({11'h100, 16'hCAFE});
    exp_q.push_back({11'h101, 16'hBEEF});
    start_load(11'h100, 12'd2);
    send_byte(8'hCA);
    bus.ld_vld = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_stall !== 1'b1 || bus.ld_rdy !== 1'b1 || bus.im_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL gap_wait: got stall=%b rdy=%b wr=%b, required 1 1 0", bus.cpu_stall, bus.ld_rdy, bus.im_wr_en);
    end
    start_load(11'h200, 12'd5);
    send_byte(8'hFE);
    bus.ld_vld = 1'b0;
    repeat (2) tick();
    send_byte(8'hBE);
    bus.ld_vld = 1'b0;
    tick();
    send_byte(8'hEF);
    bus.ld_vld = 1'b0;
    wait_done();
    tick();
    d0 = done_cnt;
    start_load(11'h300, 12'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.cpu_stall !== 1'b0 || bus.load_done !== 1'b0) begin
        n_err++;
        $display("FAIL len_zero: got stall=%b done=%b, required 0 0", bus.cpu_stall, bus.load_done);
      end
    end
    tick();
    n_cmp++;
    if (done_cnt !== d0 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL gaps_writes: got pulses=%0d pending=%0d, required 0 0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    bus.fetch_addr = 11'h0AA;
    start_load(11'h060, 12'd2);
    send_byte(8'h9A);
    bus.ld_byte = 8'h9B;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cpu_stall, bus.ld_rdy, bus.im_wr_en, bus.load_done, bus.load_err} !== 5'b0 ||
        bus.im_wdata !== 16'h0 || bus.im_addr !== 11'h0AA) begin
      n_err++;
      $display("FAIL reset_mid_load: got stall=%b rdy=%b wr=%b done=%b err=%b wdata=%h addr=%h, required 0s addr 0aa",
               bus.cpu_stall, bus.ld_rdy, bus.im_wr_en, bus.load_done, bus.load_err, bus.im_wdata, bus.im_addr);
    end
    repeat (2) tick();
    bus.ld_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_load(11'h070, 12'd1);
    bus.ld_abort = 1'b1;
    tick();
    bus.ld_abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.load_err !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drain: got err=%b stall=%b, required 1 0", bus.load_err, bus.cpu_stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.load_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err: got load_err=%b, required 0", bus.load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.fetch_addr = '0; bus.fetch_rd_en = 1'b0;
    bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_len = '0;
    bus.ld_abort = 1'b0; bus.ld_byte = '0; bus.ld_vld = 1'b0;
    test_reset();
    test_passthrough();
    test_load();
    test_wrap();
    test_abort();
    test_gaps();
    test_reset_mid_load();
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL final_pending: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
